// File: rtl/axi_lite_pkg.sv
// Shared types for the AXI-Lite memory slave: response codes and the
// read/write channel state encodings.
package axi_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_RESP
    } rd_state_e;

    typedef enum logic [2:0] {
        W_IDLE,
        W_HAVE_A,
        W_HAVE_D,
        W_WAIT,
        W_RESP
    } wr_state_e;

endpackage

// File: rtl/mem_1r1w_be.sv
// DEPTH x DATA_W array: one registered read port, one byte-enabled write port,
// read-before-write when both hit the same word in the same cycle.
module mem_1r1w_be #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4096,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rd_en,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [DATA_W-1:0]     rd_data,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [DATA_W/8-1:0]   wr_be
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array and its read register take no reset so they map onto
    // block RAM; non-blocking writes make a same-cycle read see the old word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
        if (rd_en) rd_data <= mem[rd_idx];
    end

endmodule

// File: rtl/axi_lite_mem_slave.sv
// AXI-Lite slave over a byte-strobed memory with independent read and write
// engines, configurable latencies and DECERR/SLVERR address checking.
module axi_lite_mem_slave
    import axi_lite_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 'h8000_0000,
    parameter int                RD_LAT    = 1,
    parameter int                WR_LAT    = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic                arvalid,
    output logic                arready,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rvalid,
    input  logic                rready,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wvalid,
    output logic                wready,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF    = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int RCW    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam int WCW    = (WR_LAT > 1) ? $clog2(WR_LAT) : 1;
    localparam longint unsigned MEM_BYTES = 64'(DEPTH) * 64'(STRB_W);

    // Offset is taken modulo 2^ADDR_W, so addresses below the base decode as huge.
    function automatic resp_e addr_resp(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] off;
        off = addr - BASE_ADDR;
        if (64'(off) >= MEM_BYTES) return DECERR;
        if (addr[OFF-1:0] != '0) return SLVERR;
        return OKAY;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
        return IDX_W'((addr - BASE_ADDR) >> OFF);
    endfunction

    rd_state_e           r_state, r_next;
    logic [RCW-1:0]      r_cnt;
    logic [ADDR_W-1:0]   ar_addr_q;
    resp_e               r_err, rresp_q;
    logic                ar_rdy, r_load, r_done, mem_rd_en;
    logic [DATA_W-1:0]   mem_rdata;

    wr_state_e           w_state, w_next;
    logic [WCW-1:0]      w_cnt;
    logic [ADDR_W-1:0]   aw_addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    resp_e               w_err, bresp_q;
    logic                aw_rdy, w_rdy, aw_take, w_take, w_load, w_done, mem_wr_en;

    assign r_err = addr_resp(ar_addr_q);
    assign w_err = addr_resp(aw_addr_q);

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        r_next = r_state;
        ar_rdy = 1'b0;
        rvalid = 1'b0;
        r_load = 1'b0;
        r_done = 1'b0;
        case (r_state)
            R_IDLE: begin
                ar_rdy = 1'b1;
                if (arvalid) begin
                    r_load = 1'b1;
                    r_next = R_WAIT;
                end
            end
            R_WAIT: if (r_cnt == '0) begin
                r_done = 1'b1;
                r_next = R_RESP;
            end
            R_RESP: begin
                rvalid = 1'b1;
                if (rready) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= R_IDLE;
            r_cnt     <= '0;
            ar_addr_q <= '0;
            rresp_q   <= OKAY;
        end else begin
            r_state <= r_next;
            if (r_load) begin
                ar_addr_q <= araddr;
                r_cnt     <= RCW'(RD_LAT - 1);
            end else if (r_state == R_WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - RCW'(1);
            end
            if (r_done) rresp_q <= r_err;
        end
    end

    always_comb begin
        w_next  = w_state;
        aw_rdy  = 1'b0;
        w_rdy   = 1'b0;
        aw_take = 1'b0;
        w_take  = 1'b0;
        w_load  = 1'b0;
        w_done  = 1'b0;
        bvalid  = 1'b0;
        case (w_state)
            W_IDLE: begin
                aw_rdy  = 1'b1;
                w_rdy   = 1'b1;
                aw_take = awvalid;
                w_take  = wvalid;
                if (awvalid && wvalid) begin
                    w_load = 1'b1;
                    w_next = W_WAIT;
                end else if (awvalid) begin
                    w_next = W_HAVE_A;
                end else if (wvalid) begin
                    w_next = W_HAVE_D;
                end
            end
            W_HAVE_A: begin
                w_rdy = 1'b1;
                if (wvalid) begin
                    w_take = 1'b1;
                    w_load = 1'b1;
                    w_next = W_WAIT;
                end
            end
            W_HAVE_D: begin
                aw_rdy = 1'b1;
                if (awvalid) begin
                    aw_take = 1'b1;
                    w_load  = 1'b1;
                    w_next  = W_WAIT;
                end
            end
            W_WAIT: if (w_cnt == '0) begin
                w_done = 1'b1;
                w_next = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state   <= W_IDLE;
            w_cnt     <= '0;
            aw_addr_q <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= OKAY;
        end else begin
            w_state <= w_next;
            if (aw_take) aw_addr_q <= awaddr;
            if (w_take) begin
                wdata_q <= wdata;
                wstrb_q <= wstrb;
            end
            if (w_load) begin
                w_cnt <= WCW'(WR_LAT - 1);
            end else if (w_state == W_WAIT && w_cnt != '0) begin
                w_cnt <= w_cnt - WCW'(1);
            end
            if (w_done) bresp_q <= w_err;
        end
    end

    assign mem_rd_en = r_done && (r_err == OKAY);
    assign mem_wr_en = w_done && (w_err == OKAY);

    mem_1r1w_be #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_mem (
        .clk     (clk),
        .rd_en   (mem_rd_en),
        .rd_idx  (word_idx(ar_addr_q)),
        .rd_data (mem_rdata),
        .wr_en   (mem_wr_en),
        .wr_idx  (word_idx(aw_addr_q)),
        .wr_data (wdata_q),
        .wr_be   (wstrb_q)
    );

    // Readies are masked by rst so every output reads 0 while reset is held.
    assign arready = ar_rdy & ~rst;
    assign awready = aw_rdy & ~rst;
    assign wready  = w_rdy & ~rst;
    assign rresp   = rresp_q;
    assign bresp   = bresp_q;
    assign rdata   = (r_state == R_RESP && rresp_q == OKAY) ? mem_rdata : '0;

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// Randomised and directed bench for axi_lite_mem_slave against a word-map
// reference model of the memory and the address-check rules.
module tb_axi_lite_mem_slave;

    localparam int          RD_LAT = 4;
    localparam int          WR_LAT = 3;
    localparam int          DEPTH  = 4096;
    localparam logic [31:0] BASE   = 32'h8000_0000;
    localparam int          TMO    = 50;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] araddr, awaddr, wdata, rdata;
    logic        arvalid, arready, rvalid, rready;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [3:0]  wstrb;
    logic [1:0]  rresp, bresp;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] mdl [int];

    always #5 clk = ~clk;

    axi_lite_mem_slave #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE),
        .RD_LAT    (RD_LAT),
        .WR_LAT    (WR_LAT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .araddr  (araddr),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rready  (rready),
        .awaddr  (awaddr),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] exp_resp(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        if (off >= 32'(DEPTH * 4)) return 2'b11;
        if (addr[1:0] != 2'b00) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [31:0] mdl_word(input logic [31:0] addr);
        int idx;
        idx = int'((addr - BASE) >> 2);
        return mdl.exists(idx) ? mdl[idx] : 32'h0;
    endfunction

    task automatic mdl_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        logic [31:0] w;
        if (exp_resp(addr) != 2'b00) return;
        w = mdl_word(addr);
        for (int b = 0; b < 4; b++) if (strb[b]) w[8*b +: 8] = data[8*b +: 8];
        mdl[int'((addr - BASE) >> 2)] = w;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp_data,
                            input int hold, input string tag);
        int n;
        logic [1:0] er;
        er = exp_resp(addr);
        araddr  = addr;
        arvalid = 1'b1;
        n = 0;
        while (!arready && n < TMO) begin tick(); n++; end
        check({tag, " ar_accept"}, 64'(n < TMO), 64'(1));
        tick();
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < TMO) begin tick(); n++; end
        check({tag, " r_latency"}, 64'(n), 64'(RD_LAT));
        for (int i = 0; i <= hold; i++) begin
            check({tag, " rvalid"}, 64'(rvalid), 64'(1));
            check({tag, " rdata"}, 64'(rdata), 64'((er == 2'b00) ? exp_data : 32'h0));
            check({tag, " rresp"}, 64'(rresp), 64'(er));
            if (i < hold) tick();
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check({tag, " rvalid_drop"}, 64'(rvalid), 64'(0));
    endtask

    // mode 0: AW and W together, 1: AW one cycle before W, 2: W before AW
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int mode, input int pre, input int hold, input string tag);
        int n;
        logic [1:0] er;
        logic a_done, w_done, a_hs, w_hs;
        er = exp_resp(addr);
        repeat (pre) tick();
        awaddr  = addr;
        wdata   = data;
        wstrb   = strb;
        awvalid = (mode != 2);
        wvalid  = (mode != 1);
        a_done  = 1'b0;
        w_done  = 1'b0;
        n = 0;
        while (!(a_done && w_done) && n < TMO) begin
            a_hs = awvalid && awready;
            w_hs = wvalid && wready;
            tick();
            n++;
            if (a_hs) begin a_done = 1'b1; awvalid = 1'b0; end
            if (w_hs) begin w_done = 1'b1; wvalid = 1'b0; end
            if (a_done && !w_done) wvalid = 1'b1;
            if (w_done && !a_done) awvalid = 1'b1;
        end
        check({tag, " aw_w_accept"}, 64'(a_done && w_done), 64'(1));
        n = 0;
        while (!bvalid && n < TMO) begin tick(); n++; end
        check({tag, " b_latency"}, 64'(n), 64'(WR_LAT));
        mdl_write(addr, data, strb);
        for (int i = 0; i <= hold; i++) begin
            check({tag, " bvalid"}, 64'(bvalid), 64'(1));
            check({tag, " bresp"}, 64'(bresp), 64'(er));
            if (i < hold) tick();
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check({tag, " bvalid_drop"}, 64'(bvalid), 64'(0));
    endtask

    function automatic logic [31:0] rand_addr();
        int sel;
        sel = int'($urandom_range(0, 19));
        if (sel < 14) return BASE + 32'(4 * $urandom_range(0, 15));
        if (sel < 17) return BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
        if (sel < 18) return BASE - 32'(4 * $urandom_range(1, 8));
        return BASE + 32'h4000 + 32'($urandom_range(0, 40));
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bv_seen;
        logic [31:0] a, d, old8;
        rst = 1'b0;
        {arvalid, rready, awvalid, wvalid, bready} = '0;
        araddr = '0; awaddr = '0; wdata = '0; wstrb = '0;
        #1 rst = 1'b1;
        tick();
        check("reset outputs", 64'({arready, awready, wready, rvalid, bvalid, rresp, bresp, rdata}), 64'(0));
        tick();
        rst = 1'b0;
        #1;
        check("readies after reset", 64'({arready, awready, wready}), 64'(3'b111));

        // Give every word of the test window a known value.
        for (int i = 0; i < 16; i++)
            axi_write(BASE + 32'(4 * i), $urandom, 4'hF, i % 3, 0, 0, "init");

        axi_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 1, 0, 0, "wr_full");
        axi_read (32'h8000_0010, 32'hDEAD_BEEF, 0, "rd_full");
        axi_write(32'h8000_0010, 32'h0000_AA00, 4'b0010, 2, 0, 1, "wr_partial");
        axi_read (32'h8000_0010, 32'hDEAD_AAEF, 0, "rd_partial");
        axi_read (32'h7FFF_FFF0, 32'h0, 0, "rd_decerr");
        axi_write(32'h8000_0012, 32'h1111_1111, 4'hF, 0, 0, 0, "wr_slverr");
        axi_read (32'h8000_0010, 32'hDEAD_AAEF, 0, "rd_after_slverr");
        axi_write(32'h8000_0010, 32'hFFFF_FFFF, 4'h0, 0, 0, 0, "wr_nostrb");
        axi_read (32'h8000_0010, 32'hDEAD_AAEF, 0, "rd_after_nostrb");
        axi_write(32'h8000_3FFC, 32'hCAFE_F00D, 4'hF, 0, 0, 0, "wr_last_word");
        axi_read (32'h8000_3FFC, 32'hCAFE_F00D, 0, "rd_last_word");
        axi_read (32'h8000_4000, 32'h0, 0, "rd_past_end");
        axi_write(32'h8000_4002, 32'h2222_2222, 4'hF, 0, 0, 0, "wr_dec_over_slv");
        axi_read (32'h8000_3FFE, 32'h0, 0, "rd_unaligned");

        // Independent channels: AR and AW+W in the same cycle, R held back.
        d = mdl_word(32'h8000_0020);
        fork
            axi_read (32'h8000_0020, d, 5, "conc_rd");
            axi_write(32'h8000_0024, 32'h5A5A_A5A5, 4'hF, 0, 0, 0, "conc_wr");
        join

        // Read sample and write commit land on the same edge.
        axi_write(32'h8000_0014, 32'h1, 4'hF, 0, 0, 0, "coll_setup");
        fork
            axi_read (32'h8000_0014, 32'h1, 0, "coll_rd_old");
            axi_write(32'h8000_0014, 32'h2, 4'hF, 0, 1, 0, "coll_wr");
        join
        axi_read(32'h8000_0014, 32'h2, 0, "coll_rd_new");

        // Reset while the write is still counting down.
        old8 = mdl_word(32'h8000_0020);
        awaddr = 32'h8000_0020; wdata = ~old8; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check("rst mid-write outputs", 64'({arready, awready, wready, rvalid, bvalid}), 64'(0));
        tick();
        check("rst held outputs", 64'({arready, awready, wready, rvalid, bvalid}), 64'(0));
        rst = 1'b0;
        #1;
        check("readies after mid reset", 64'({arready, awready, wready}), 64'(3'b111));
        bv_seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bvalid) bv_seen++;
        end
        check("no bvalid after reset", 64'(bv_seen), 64'(0));
        axi_read(32'h8000_0020, old8, 0, "rd_after_reset");

        for (int i = 0; i < 60; i++) begin
            a = rand_addr();
            if ($urandom_range(0, 1) == 0)
                axi_read(a, mdl_word(a), int'($urandom_range(0, 2)), "rand_rd");
            else
                axi_write(a, $urandom, 4'($urandom), int'($urandom_range(0, 2)), 0,
                          int'($urandom_range(0, 2)), "rand_wr");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
